// File: rtl/calc_operand_entry.sv
// calc_operand_entry: pushbutton front end for the two-operand calculator.
//   Five raw buttons are synchronized, debounced and edge-detected; the
//   resulting press pulses drive a small edit FSM owning two 5-bit operands
//   and a 1-bit operator.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   btn_inc/dec/sel/op/enter   raw buttons
//   in0, in1 [4:0]      operands to calculator
//   op                  0 = add, 1 = multiply
//   state [1:0]         00 EDIT0, 01 EDIT1, 10 SHOW
//   commit              one-cycle pulse on the first SHOW cycle

// Per-button conditioner: 2-FF sync, debounce counter, registered rise pulse.
module calc_btn_cond #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_db;
  logic          r_db_q;
  logic          r_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_db    <= 1'b0;
      r_db_q  <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      // Flip only after DEBOUNCE_CYCLES consecutive disagreeing cycles;
      // a single agreeing cycle restarts the count.
      if (r_sync[1] != r_db) begin
        if (r_cnt == LAST) begin
          r_db  <= r_sync[1];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
      r_db_q  <= r_db;
      r_press <= r_db & ~r_db_q;
    end
  end

  assign o_press = r_press;
endmodule

module calc_operand_entry #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_sel,
  input  logic       btn_op,
  input  logic       btn_enter,
  output logic [4:0] in0,
  output logic [4:0] in1,
  output logic       op,
  output logic [1:0] state,
  output logic       commit
);
  localparam logic [1:0] EDIT0 = 2'b00;
  localparam logic [1:0] EDIT1 = 2'b01;
  localparam logic [1:0] SHOW  = 2'b10;

  localparam int B_INC = 0, B_DEC = 1, B_SEL = 2, B_OP = 3, B_ENT = 4;

  logic [4:0] w_btn_raw;
  logic [4:0] w_press;

  assign w_btn_raw = {btn_enter, btn_op, btn_sel, btn_dec, btn_inc};

  calc_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn [4:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (w_btn_raw),
    .o_press (w_press)
  );

  logic [4:0] r_in0, r_in1;
  logic       r_op;
  logic [1:0] r_state;
  logic       r_commit;

  logic [4:0] w_in0_nxt, w_in1_nxt;
  logic       w_op_nxt;
  logic [1:0] w_state_nxt;
  logic       w_commit_nxt;
  logic       w_step;
  logic [4:0] w_delta;

  // inc and dec together cancel; otherwise add +1 or +31 (== -1 mod 32).
  assign w_step  = w_press[B_INC] ^ w_press[B_DEC];
  assign w_delta = w_press[B_INC] ? 5'd1 : 5'd31;

  always_comb begin
    w_in0_nxt    = r_in0;
    w_in1_nxt    = r_in1;
    w_op_nxt     = r_op;
    w_state_nxt  = r_state;
    w_commit_nxt = 1'b0;
    case (r_state)
      EDIT0, EDIT1: begin
        // One action per cycle: enter > sel > op > inc/dec.
        if (w_press[B_ENT]) begin
          w_state_nxt  = SHOW;
          w_commit_nxt = 1'b1;
        end else if (w_press[B_SEL]) begin
          w_state_nxt = (r_state == EDIT0) ? EDIT1 : EDIT0;
        end else if (w_press[B_OP]) begin
          w_op_nxt = ~r_op;
        end else if (w_step) begin
          if (r_state == EDIT0) w_in0_nxt = r_in0 + w_delta;
          else                  w_in1_nxt = r_in1 + w_delta;
        end
      end
      SHOW: begin
        if (w_press[B_ENT]) w_state_nxt = EDIT0;
      end
      default: w_state_nxt = EDIT0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in0    <= '0;
      r_in1    <= '0;
      r_op     <= 1'b0;
      r_state  <= EDIT0;
      r_commit <= 1'b0;
    end else begin
      r_in0    <= w_in0_nxt;
      r_in1    <= w_in1_nxt;
      r_op     <= w_op_nxt;
      r_state  <= w_state_nxt;
      r_commit <= w_commit_nxt;
    end
  end

  assign in0    = r_in0;
  assign in1    = r_in1;
  assign op     = r_op;
  assign state  = r_state;
  assign commit = r_commit;
endmodule

// File: tb/tb_calc_operand_entry.sv
// Testbench for calc_operand_entry: scoreboard of expected output updates
// (value and arrival cycle) pushed at press time, popped by an output monitor.
module tb_calc_operand_entry;
  localparam logic [1:0] EDIT0 = 2'b00;
  localparam logic [1:0] EDIT1 = 2'b01;
  localparam logic [1:0] SHOW  = 2'b10;
  localparam int LAT = 8;  // drive negedge -> edge k+7 is 8 posedges later

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn = '0;   // {enter, op, sel, dec, inc}
  logic [4:0] in0, in1;
  logic       op, commit;
  logic [1:0] state;

  calc_operand_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_inc   (btn[0]),
    .btn_dec   (btn[1]),
    .btn_sel   (btn[2]),
    .btn_op    (btn[3]),
    .btn_enter (btn[4]),
    .in0       (in0),
    .in1       (in1),
    .op        (op),
    .state     (state),
    .commit    (commit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] in0;
    logic [4:0] in1;
    logic       op;
    logic [1:0] st;
    int         cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int n_chk = 0, n_pass = 0, cyc = 0, n_commit = 0;
  logic [4:0] m_in0 = '0, m_in1 = '0;
  logic       m_op = 1'b0;
  logic [1:0] m_st = EDIT0;
  logic [13:0] cur, prev = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: every change of the visible outputs must match the head
  // of the scoreboard, both in value and in the cycle it appears.
  always @(negedge clk) begin
    cur = {state, op, in1, in0};
    if (!rst_n) prev = cur;
    else begin
      if (commit) begin
        n_commit++;
        chk("commit_in_show", {30'd0, state}, {30'd0, SHOW});
      end
      if (cur != prev) begin
        if (sbq.size() == 0) chk("sb_unexpected", {18'd0, cur}, {18'd0, prev});
        else begin
          e = sbq.pop_front();
          chk("sb_out", {18'd0, cur}, {18'd0, e.st, e.op, e.in1, e.in0});
          chk("sb_lat", cyc, e.cyc);
        end
        prev = cur;
      end
    end
  end

  // Reference behaviour for one set of coincident press pulses.
  task automatic model(input logic [4:0] m);
    logic [4:0] o0, o1;
    logic       oo;
    logic [1:0] os;
    exp_t x;
    o0 = m_in0; o1 = m_in1; oo = m_op; os = m_st;
    if (m_st == SHOW) begin
      if (m[4]) m_st = EDIT0;
    end else if (m[4]) m_st = SHOW;
    else if (m[2]) m_st = (m_st == EDIT0) ? EDIT1 : EDIT0;
    else if (m[3]) m_op = ~m_op;
    else if (m[0] != m[1]) begin
      if (m_st == EDIT0) m_in0 = m[0] ? m_in0 + 5'd1 : m_in0 - 5'd1;
      else               m_in1 = m[0] ? m_in1 + 5'd1 : m_in1 - 5'd1;
    end
    if ({o0, o1, oo, os} != {m_in0, m_in1, m_op, m_st}) begin
      x.in0 = m_in0; x.in1 = m_in1; x.op = m_op; x.st = m_st; x.cyc = cyc + LAT;
      sbq.push_back(x);
    end
  endtask

  // Called at a negedge; hold/gap counted in cycles.
  task automatic press(input logic [4:0] m, input int hold, input int gap, input bit acts);
    if (acts) model(m);
    btn = m;
    repeat (hold) @(negedge clk);
    btn = '0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic tap(input logic [4:0] m, input int n);
    for (int i = 0; i < n; i++) press(m, 10, 10, 1'b1);
  endtask

  task automatic settle(input string tag);
    chk({tag, "_sbq"}, sbq.size(), 0);
    chk({tag, "_in0"}, {27'd0, in0}, {27'd0, m_in0});
    chk({tag, "_in1"}, {27'd0, in1}, {27'd0, m_in1});
    chk({tag, "_op"}, {31'd0, op}, {31'd0, m_op});
    chk({tag, "_st"}, {30'd0, state}, {30'd0, m_st});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in0", {27'd0, in0}, 0);
    chk("rst_in1", {27'd0, in1}, 0);
    chk("rst_op", {31'd0, op}, 0);
    chk("rst_st", {30'd0, state}, {30'd0, EDIT0});
    chk("rst_commit", {31'd0, commit}, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // 3 inc, sel, 2 dec -> in0=3, in1=30, EDIT1
    tap(5'b00001, 3);
    tap(5'b00100, 1);
    tap(5'b00010, 2);
    settle("basic");
    chk("basic_in0_abs", {27'd0, in0}, 3);
    chk("basic_in1_abs", {27'd0, in1}, 30);

    // Back to EDIT0, bring in0 to 0, then wrap
    tap(5'b00100, 1);
    tap(5'b00010, 3);
    tap(5'b00001, 32);
    settle("wrap32");
    chk("wrap32_abs", {27'd0, in0}, 0);
    tap(5'b00010, 1);
    chk("wrap_dec_abs", {27'd0, in0}, 31);
    tap(5'b00001, 1);

    // Glitch of 3 cycles must not act; 5-cycle hold acts once at k+7
    press(5'b00001, 3, 20, 1'b0);
    settle("glitch");
    press(5'b00001, 5, 30, 1'b1);
    settle("hold5");
    chk("hold5_abs", {27'd0, in0}, 1);

    // op then enter -> SHOW with single commit pulse
    tap(5'b01000, 1);
    n_commit = 0;
    tap(5'b10000, 1);
    chk("commit_cnt", n_commit, 1);
    settle("show");
    chk("show_op_abs", {31'd0, op}, 1);
    tap(5'b00001, 1);
    tap(5'b01000, 1);
    settle("show_ignore");
    n_commit = 0;
    tap(5'b10000, 1);
    chk("reenter_nocommit", n_commit, 0);
    settle("reenter");

    // Coincident presses
    tap(5'b10001, 1);
    settle("ent_inc");
    tap(5'b10000, 1);
    tap(5'b00011, 1);
    settle("inc_dec");
    tap(5'b00101, 1);
    settle("sel_inc");
    tap(5'b00100, 1);

    // Reset mid-debounce with in0 = 5, button held through release
    tap(5'b00001, 4);
    chk("pre_rst_in0", {27'd0, in0}, 5);
    btn = 5'b00001;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in0", {27'd0, in0}, 0);
    chk("arst_in1", {27'd0, in1}, 0);
    chk("arst_op", {31'd0, op}, 0);
    chk("arst_st", {30'd0, state}, {30'd0, EDIT0});
    chk("arst_commit", {31'd0, commit}, 0);
    m_in0 = '0; m_in1 = '0; m_op = 1'b0; m_st = EDIT0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    model(5'b00001);
    repeat (15) @(negedge clk);
    btn = '0;
    repeat (15) @(negedge clk);
    settle("post_rst");
    chk("post_rst_abs", {27'd0, in0}, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
